// File: rtl/code_lock_pkg.sv
// code_lock_pkg: shared types and helpers for the keypad combination lock.
//   - lock_state_t : controller states (ST_LOCKOUT exists only when the
//                    LOCK_LOCKOUT_EN macro is defined)
//   - KEY_*        : bit positions of the non-digit keys in the keypad vector
//   - key_to_bcd   : maps a one-hot keypad vector to its BCD digit
package code_lock_pkg;

`ifdef LOCK_LOCKOUT_EN
  typedef enum logic [2:0] {
    ST_LOCKED,
    ST_OPEN,
    ST_NEW1,
    ST_NEW2,
    ST_LOCKOUT
  } lock_state_t;
`else
  typedef enum logic [1:0] {
    ST_LOCKED,
    ST_OPEN,
    ST_NEW1,
    ST_NEW2
  } lock_state_t;
`endif

  localparam int KEY_ENTER  = 9;
  localparam int KEY_ZERO   = 10;
  localparam int KEY_CHANGE = 11;

  // Bits 0..8 carry digits 1..9; the zero key (and any non-digit key)
  // yields 4'd0, which is exactly the BCD value wanted for the zero key.
  function automatic logic [3:0] key_to_bcd(input logic [11:0] key);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < 9; i++) begin
      if (key[i]) d = 4'(i + 1);
    end
    return d;
  endfunction

endpackage

// File: rtl/code_lock_keyscan.sv
// code_lock_keyscan: registers the raw keypad vector and turns a fresh
// single-key press into a one-cycle event.
// Ports:
//   clock, reset      : system clock, asynchronous active-low reset
//   key[11:0]         : raw one-hot keypad vector
//   press             : one-cycle pulse for a new, single-key press
//   is_digit/is_enter/is_change : qualifiers, valid only while press is high
//   digit[3:0]        : BCD value of the pressed digit key
module code_lock_keyscan
  import code_lock_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] key,
  output logic        press,
  output logic        is_digit,
  output logic        is_enter,
  output logic        is_change,
  output logic [3:0]  digit
);

  logic [11:0] key_reg;
  logic [11:0] key_prev_reg;
  logic        one_hot;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      key_reg      <= '0;
      key_prev_reg <= '0;
    end else begin
      key_reg      <= key;
      key_prev_reg <= key_reg;
    end
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  assign one_hot = (key_reg != 12'd0) && ((key_reg & (key_reg - 12'd1)) == 12'd0);

  // Only a release-to-press transition counts, so held keys and chords
  // (multi-hot, or sliding from one key to another) never fire.
  assign press     = one_hot && (key_prev_reg == 12'd0);
  assign is_enter  = press && key_reg[KEY_ENTER];
  assign is_change = press && key_reg[KEY_CHANGE];
  assign is_digit  = press && !key_reg[KEY_ENTER] && !key_reg[KEY_CHANGE];
  assign digit     = key_to_bcd(key_reg);

endmodule

// File: rtl/code_lock_top.sv
// code_lock_top: four-digit keypad combination lock controller.
// Optional feature macro: LOCK_LOCKOUT_EN (fail counter + timed lockout).
// Ports:
//   clock, reset  : system clock, asynchronous active-low reset
//   Key[11:0]     : one-hot keypad (0..8 = digits 1..9, 9 = '#', 10 = 0, 11 = '*')
//   set_1         : admin restore switch (level)
//   OPEN_1        : lock released
//   SAVE_LIGHT_1  : new code saved, held until the next key event
//   LOCK_1        : locked indicator (inverse of OPEN_1)
//   CHANGE        : code-change mode active
//   SET           : registered admin restore
//   data[15:0]    : current entry, most recent digit in [3:0]
module code_lock_top
  import code_lock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE = 16'h2432,
  parameter int          OPEN_CYCLES  = 100
`ifdef LOCK_LOCKOUT_EN
  ,
  parameter int          MAX_FAILS      = 3,
  parameter int          LOCKOUT_CYCLES = 1000
`endif
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] Key,
  input  logic        set_1,
  output logic        OPEN_1,
  output logic        SAVE_LIGHT_1,
  output logic        LOCK_1,
  output logic        CHANGE,
  output logic        SET,
  output logic [15:0] data
);

`ifdef LOCK_LOCKOUT_EN
  localparam int TIMER_MAX = (LOCKOUT_CYCLES > OPEN_CYCLES) ? LOCKOUT_CYCLES : OPEN_CYCLES;
  localparam int FAIL_W    = $clog2(MAX_FAILS + 1);
`else
  localparam int TIMER_MAX = OPEN_CYCLES;
`endif
  localparam int TIMER_W = $clog2(TIMER_MAX + 1);
  // The timer counts down to zero, so a load of N-1 gives N open cycles.
  localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
`ifdef LOCK_LOCKOUT_EN
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCKOUT_CYCLES - 1);
`endif

  logic       press;
  logic       is_digit;
  logic       is_enter;
  logic       is_change;
  logic [3:0] digit;

  code_lock_keyscan u_keyscan (
    .clock     (clock),
    .reset     (reset),
    .key       (Key),
    .press     (press),
    .is_digit  (is_digit),
    .is_enter  (is_enter),
    .is_change (is_change),
    .digit     (digit)
  );

  lock_state_t        state_reg, state_next, eff_state;
  logic [2:0]         count_reg, count_next;
  logic [15:0]        data_reg, data_next;
  logic [15:0]        code_reg, code_next;
  logic [15:0]        temp_reg, temp_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic               save_reg, save_next;
  logic               open_reg, open_next;
  logic               lock_reg, lock_next;
  logic               change_reg, change_next;
  logic               set_reg;
  logic               full;
  logic               code_match;
  logic               keys_live;
`ifdef LOCK_LOCKOUT_EN
  logic [FAIL_W-1:0]  fail_reg, fail_next;
  assign keys_live = (state_reg != ST_LOCKOUT);
`else
  assign keys_live = 1'b1;
`endif

  // State register (all outputs are registered here too).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_LOCKED;
      count_reg  <= '0;
      data_reg   <= '0;
      code_reg   <= DEFAULT_CODE;
      temp_reg   <= '0;
      timer_reg  <= '0;
      save_reg   <= 1'b0;
      open_reg   <= 1'b0;
      lock_reg   <= 1'b1;
      change_reg <= 1'b0;
      set_reg    <= 1'b0;
`ifdef LOCK_LOCKOUT_EN
      fail_reg   <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      data_reg   <= data_next;
      code_reg   <= code_next;
      temp_reg   <= temp_next;
      timer_reg  <= timer_next;
      save_reg   <= save_next;
      open_reg   <= open_next;
      lock_reg   <= lock_next;
      change_reg <= change_next;
      set_reg    <= set_1;
`ifdef LOCK_LOCKOUT_EN
      fail_reg   <= fail_next;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    data_next  = data_reg;
    code_next  = code_reg;
    temp_next  = temp_reg;
    timer_next = timer_reg;
    save_next  = save_reg;
    eff_state  = state_reg;
`ifdef LOCK_LOCKOUT_EN
    fail_next  = fail_reg;
`endif
    full       = (count_reg == 3'd4);
    code_match = full && (data_reg == code_reg);

    // set_1 is acted on at the same edge that raises SET, so the forced
    // state coincides exactly with the cycles SET is visible.
    if (set_1) begin
      state_next = ST_LOCKED;
      code_next  = DEFAULT_CODE;
      data_next  = '0;
      count_next = '0;
      timer_next = '0;
`ifdef LOCK_LOCKOUT_EN
      fail_next  = '0;
`endif
    end else if (press && keys_live) begin
      save_next = 1'b0;
      // A key in OPEN relocks and is then handled as a LOCKED key; this also
      // covers a timer expiry landing on the same cycle.
      eff_state  = (state_reg == ST_OPEN) ? ST_LOCKED : state_reg;
      state_next = eff_state;
      if (is_digit) begin
        data_next = {data_reg[11:0], digit};
        if (!full) count_next = count_reg + 3'd1;
      end else begin
        data_next  = '0;
        count_next = '0;
        case (eff_state)
          ST_LOCKED: begin
            if (code_match) begin
              if (is_enter) begin
                state_next = ST_OPEN;
                timer_next = OPEN_LOAD;
`ifdef LOCK_LOCKOUT_EN
                fail_next  = '0;
`endif
              end else begin
                state_next = ST_NEW1;
              end
            end else begin
`ifdef LOCK_LOCKOUT_EN
              if (is_enter) begin
                // The counter restarts after each lockout period.
                if (int'(fail_reg) + 1 >= MAX_FAILS) begin
                  state_next = ST_LOCKOUT;
                  timer_next = LOCK_LOAD;
                  fail_next  = '0;
                end else begin
                  fail_next = fail_reg + FAIL_W'(1);
                end
              end
`endif
            end
          end
          ST_NEW1: begin
            if (is_enter && full) begin
              temp_next  = data_reg;
              state_next = ST_NEW2;
            end else begin
              state_next = ST_LOCKED;
            end
          end
          ST_NEW2: begin
            if (is_enter && full && (data_reg == temp_reg)) begin
              code_next = temp_reg;
              save_next = 1'b1;
`ifdef LOCK_LOCKOUT_EN
              fail_next = '0;
`endif
            end
            state_next = ST_LOCKED;
          end
          default: state_next = ST_LOCKED;
        endcase
      end
    end else if (state_reg == ST_OPEN) begin
      if (timer_reg == '0) state_next = ST_LOCKED;
      else                 timer_next = timer_reg - TIMER_W'(1);
    end
`ifdef LOCK_LOCKOUT_EN
    else if (state_reg == ST_LOCKOUT) begin
      if (timer_reg == '0) state_next = ST_LOCKED;
      else                 timer_next = timer_reg - TIMER_W'(1);
    end
`endif
  end

  // Output decode from the next state, registered alongside the state.
  always_comb begin
    open_next   = (state_next == ST_OPEN);
    lock_next   = !open_next;
    change_next = (state_next == ST_NEW1) || (state_next == ST_NEW2);
  end

  assign OPEN_1       = open_reg;
  assign LOCK_1       = lock_reg;
  assign CHANGE       = change_reg;
  assign SAVE_LIGHT_1 = save_reg;
  assign SET          = set_reg;
  assign data         = data_reg;

endmodule

// File: tb/tb_code_lock_top.sv
// tb_code_lock_top: scoreboard bench for code_lock_top.
// Stimulus updates a decimal-number reference model and queues every
// expected output change with the cycle it must appear on; an independent
// monitor pops and compares whenever the DUT outputs change.
module tb_code_lock_top;

  localparam int          N_OPEN  = 100;
  localparam logic [15:0] DEF_BCD = 16'h2432;
  localparam int          DEF_NUM = 2432;
  localparam logic [11:0] K_ENTER  = 12'h200;
  localparam logic [11:0] K_CHANGE = 12'h800;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [11:0] Key   = '0;
  logic        set_1 = 1'b0;
  logic        OPEN_1, SAVE_LIGHT_1, LOCK_1, CHANGE, SET;
  logic [15:0] data;

  code_lock_top #(.DEFAULT_CODE(DEF_BCD), .OPEN_CYCLES(N_OPEN)) dut (
    .clock        (clock),
    .reset        (reset),
    .Key          (Key),
    .set_1        (set_1),
    .OPEN_1       (OPEN_1),
    .SAVE_LIGHT_1 (SAVE_LIGHT_1),
    .LOCK_1       (LOCK_1),
    .CHANGE       (CHANGE),
    .SET          (SET),
    .data         (data)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [20:0] v;
    int          t;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: entry and codes held as decimal numbers.
  int          m_mode = 0;      // 0 locked, 1 open, 2 first new entry, 3 confirm
  int          m_num  = 0;
  int          m_len  = 0;
  int          m_code = DEF_NUM;
  int          m_temp = 0;
  int          m_open_until = 0;
  bit          m_save = 0;
  bit          m_set  = 0;
  logic [20:0] last_exp = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000};

  function automatic logic [15:0] to_bcd(int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  function automatic logic [20:0] m_snap();
    return {(m_mode == 1), m_save, (m_mode != 1), (m_mode >= 2), m_set, to_bcd(m_num)};
  endfunction

  function automatic logic [20:0] outs();
    return {OPEN_1, SAVE_LIGHT_1, LOCK_1, CHANGE, SET, data};
  endfunction

  function automatic void m_push(int t);
    logic [20:0] s;
    exp_t e;
    s = m_snap();
    if (s != last_exp) begin
      e.v = s;
      e.t = t;
      exp_q.push_back(e);
      last_exp = s;
    end
  endfunction

  // Account for an open-period expiry at or before cycle h.
  function automatic void m_flush(int h);
    if (m_mode == 1 && m_open_until <= h) begin
      m_mode = 0;
      m_push(m_open_until);
    end
  endfunction

  function automatic void m_key(int t, int idx);
    bit full, match;
    m_flush(t - 1);
    if (m_set) return;
    m_save = 0;
    if (m_mode == 1) m_mode = 0;
    full  = (m_len == 4);
    match = full && (m_num == m_code);
    if (idx == 9 || idx == 11) begin
      case (m_mode)
        0: if (match) begin
             if (idx == 9) begin
               m_mode = 1;
               m_open_until = t + N_OPEN;
             end else begin
               m_mode = 2;
             end
           end
        2: if (idx == 9 && full) begin
             m_temp = m_num;
             m_mode = 3;
           end else begin
             m_mode = 0;
           end
        3: begin
             if (idx == 9 && full && m_num == m_temp) begin
               m_code = m_temp;
               m_save = 1;
             end
             m_mode = 0;
           end
        default: m_mode = 0;
      endcase
      m_num = 0;
      m_len = 0;
    end else begin
      m_num = (m_num * 10 + ((idx == 10) ? 0 : idx + 1)) % 10000;
      if (m_len < 4) m_len++;
    end
    m_push(t);
  endfunction

  function automatic void m_set_level(int t, bit v);
    m_flush(t - 1);
    m_set = v;
    if (v) begin
      m_mode = 0;
      m_num  = 0;
      m_len  = 0;
      m_code = DEF_NUM;
    end
    m_push(t);
  endfunction

  function automatic logic [11:0] kd(int d);
    logic [11:0] one;
    one = 12'd1;
    return one << ((d == 0) ? 10 : d - 1);
  endfunction

  function automatic int idx_of(logic [11:0] k);
    for (int i = 0; i < 12; i++) if (k[i]) return i;
    return -1;
  endfunction

  task automatic step();
    @(negedge clock);
    m_flush(cyc + 1);
  endtask

  // Hold a key for 10 cycles, then release for 10 cycles.
  task automatic press(input logic [11:0] k);
    @(negedge clock);
    Key = k;
    if ($onehot(k)) m_key(cyc + 2, idx_of(k));
    repeat (10) step();
    Key = '0;
    repeat (10) step();
  endtask

  task automatic type_num(input int n);
    press(kd(n / 1000));
    press(kd((n / 100) % 10));
    press(kd((n / 10) % 10));
    press(kd(n % 10));
  endtask

  task automatic set_pulse(input int len);
    @(negedge clock);
    set_1 = 1'b1;
    m_set_level(cyc + 1, 1);
    repeat (len) step();
    set_1 = 1'b0;
    m_set_level(cyc + 1, 0);
    repeat (3) step();
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s got=%h required=%h at cycle %0d", name, got, req, cyc);
    end
  endtask

  // Monitor: every change of the output vector must match the next queued entry.
  initial begin
    logic [20:0] prev, cur;
    exp_t e;
    @(posedge reset);
    @(negedge clock);
    prev = outs();
    forever begin
      @(negedge clock);
      cur = outs();
      if (cur !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change got=%h at cycle %0d required=no change", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e.v || cyc != e.t) begin
            failures++;
            $display("FAIL outputs got=%h@%0d required=%h@%0d", cur, cyc, e.v, e.t);
          end
        end
        prev = cur;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int          r, n, a, b;
    logic [11:0] k;

    #20;
    chk("reset_outputs", 16'(outs() >> 16), 16'b00100);
    chk("reset_data", data, 16'h0000);
    #30;
    reset = 1'b1;
    repeat (3) step();

    // Default code opens, then times out.
    type_num(2432);
    chk("entry_2432", data, 16'h2432);
    press(K_ENTER);
    chk("open_after_enter", {15'd0, OPEN_1}, 16'd1);
    chk("lock_low_when_open", {15'd0, LOCK_1}, 16'd0);
    repeat (N_OPEN) step();
    chk("relock_after_timeout", {15'd0, LOCK_1}, 16'd1);

    // Change the code to 0113.
    type_num(2432);
    press(K_CHANGE);
    chk("change_mode", {15'd0, CHANGE}, 16'd1);
    type_num(113);
    press(K_ENTER);
    type_num(113);
    press(K_ENTER);
    chk("save_light", {15'd0, SAVE_LIGHT_1}, 16'd1);
    chk("change_cleared", {15'd0, CHANGE}, 16'd0);

    // New code opens, old code no longer does.
    type_num(113);
    press(K_ENTER);
    chk("open_new_code", {15'd0, OPEN_1}, 16'd1);
    repeat (N_OPEN) step();
    type_num(2432);
    press(K_ENTER);
    chk("old_code_rejected", {15'd0, OPEN_1}, 16'd0);

    // Confirmation mismatch keeps the existing code.
    type_num(113);
    press(K_CHANGE);
    type_num(113);
    press(K_ENTER);
    type_num(114);
    press(K_ENTER);
    chk("mismatch_no_save", {15'd0, SAVE_LIGHT_1}, 16'd0);
    chk("mismatch_exit_change", {15'd0, CHANGE}, 16'd0);
    type_num(113);
    press(K_ENTER);
    chk("code_kept_opens", {15'd0, OPEN_1}, 16'd1);
    repeat (N_OPEN) step();
    press(kd(1));
    press(kd(1));
    press(kd(3));
    press(K_ENTER);
    chk("three_digits_rejected", {15'd0, OPEN_1}, 16'd0);

    // Admin restore for 5 cycles with a key pressed inside the window.
    @(negedge clock);
    set_1 = 1'b1;
    m_set_level(cyc + 1, 1);
    step();
    Key = kd(2);
    step();
    step();
    chk("set_flag", {15'd0, SET}, 16'd1);
    chk("key_ignored_in_set", data, 16'h0000);
    Key = '0;
    step();
    step();
    set_1 = 1'b0;
    m_set_level(cyc + 1, 0);
    repeat (5) step();
    chk("set_released", {15'd0, SET}, 16'd0);
    type_num(DEF_NUM);
    press(K_ENTER);
    chk("default_restored", {15'd0, OPEN_1}, 16'd1);

    // Two keys at once produce no event and do not relock.
    press(kd(1) | kd(2));
    chk("chord_keeps_open", {15'd0, OPEN_1}, 16'd1);
    chk("chord_no_digit", data, 16'h0000);

    // Randomized phase.
    for (int it = 0; it < 70; it++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2: begin
          type_num(m_code);
          press(K_ENTER);
        end
        3: begin
          type_num(m_code);
          press(K_CHANGE);
          n = $urandom_range(0, 9999);
          type_num(n);
          press(K_ENTER);
          if ($urandom_range(0, 1) == 1) type_num(n);
          else                           type_num($urandom_range(0, 9999));
          press(K_ENTER);
        end
        4: begin
          a = $urandom_range(0, 9);
          b = (a + 1 + $urandom_range(0, 8)) % 10;
          press(kd(a) | kd(b));
        end
        5: set_pulse($urandom_range(1, 6));
        6: repeat ($urandom_range(0, 130)) step();
        default: begin
          k = 12'd1;
          k = k << $urandom_range(0, 11);
          press(k);
        end
      endcase
    end

    repeat (N_OPEN + 10) step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_changes got=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
